// File: rtl/mem_pkg.sv
// Shared encodings for the MEM-stage data-memory access path:
// load/store type codes and the access sequencer state.
package mem_pkg;

    localparam logic [2:0] LT_WORD  = 3'd0;
    localparam logic [2:0] LT_BYTE  = 3'd1;
    localparam logic [2:0] LT_SBYTE = 3'd2;
    localparam logic [2:0] LT_HALF  = 3'd3;
    localparam logic [2:0] LT_SHALF = 3'd4;

    localparam logic [1:0] ST_WORD = 2'd0;
    localparam logic [1:0] ST_BYTE = 2'd1;
    localparam logic [1:0] ST_HALF = 2'd2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } stateT;

endpackage

// File: rtl/load_extract.sv
// Selects the addressed byte/half lane of a read word and zero- or
// sign-extends it according to the load type.
module load_extract
    import mem_pkg::*;
(
    input  logic [31:0] word,
    input  logic [2:0]  loadType,
    input  logic [1:0]  offset,
    output logic [31:0] extWord
);

    logic [7:0]  byteLane;
    logic [15:0] halfLane;

    always_comb begin
        byteLane = word[7:0];
        case (offset)
            2'd0: byteLane = word[7:0];
            2'd1: byteLane = word[15:8];
            2'd2: byteLane = word[23:16];
            2'd3: byteLane = word[31:24];
            default: byteLane = word[7:0];
        endcase
        halfLane = offset[1] ? word[31:16] : word[15:0];
    end

    always_comb begin
        extWord = '0;
        case (loadType)
            LT_WORD:  extWord = word;
            LT_BYTE:  extWord = {24'd0, byteLane};
            LT_SBYTE: extWord = {{24{byteLane[7]}}, byteLane};
            LT_HALF:  extWord = {16'd0, halfLane};
            LT_SHALF: extWord = {{16{halfLane[15]}}, halfLane};
            default:  extWord = '0;
        endcase
    end

endmodule

// File: rtl/dmem_access_ctrl.sv
// MEM-stage data-memory sequencer: one req/ack transaction per load/store,
// pipeline stall while in flight, misalignment and bus-timeout reporting.
module dmem_access_ctrl
    import mem_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [2:0]  load_type,
    input  logic [1:0]  store_type,
    output logic        stall,
    output logic        done,
    output logic [31:0] rdata,
    output logic        exc_adel,
    output logic        exc_ades,
    output logic        bus_err,
    output logic        m_req,
    output logic        m_we,
    output logic [31:0] m_addr,
    output logic [3:0]  m_be,
    output logic [31:0] m_wdata,
    input  logic        m_ack,
    input  logic [31:0] m_rdata
);

    localparam logic [7:0] CNT_LIMIT = 8'(TIMEOUT - 1);

    stateT       state, nextState;
    logic [7:0]  waitCnt;
    logic [2:0]  loadTypeQ;
    logic [1:0]  offsetQ;
    logic [31:0] extWord;
    logic        opPresent, isLoad, misaligned, stallRaw;
    logic [3:0]  beNext;
    logic [31:0] wdataNext;

    assign opPresent = mem_read | mem_write;
    assign isLoad    = mem_read;

    load_extract uExtract (
        .word     (m_rdata),
        .loadType (loadTypeQ),
        .offset   (offsetQ),
        .extWord  (extWord)
    );

    // Alignment check and store lane steering; loads always fetch the full word.
    always_comb begin
        misaligned = 1'b0;
        beNext     = 4'b1111;
        wdataNext  = '0;
        if (isLoad) begin
            case (load_type)
                LT_WORD:           misaligned = |addr[1:0];
                LT_HALF, LT_SHALF: misaligned = addr[0];
                default:           misaligned = 1'b0;
            endcase
        end else begin
            case (store_type)
                ST_BYTE: begin
                    beNext    = 4'b0001 << addr[1:0];
                    wdataNext = {4{wdata[7:0]}};
                end
                ST_HALF: begin
                    misaligned = addr[0];
                    beNext     = addr[1] ? 4'b1100 : 4'b0011;
                    wdataNext  = {2{wdata[15:0]}};
                end
                default: begin
                    misaligned = |addr[1:0];
                    wdataNext  = wdata;
                end
            endcase
        end
    end

    always_comb begin
        nextState = state;
        stallRaw  = 1'b0;
        case (state)
            IDLE: begin
                if (opPresent) begin
                    stallRaw  = 1'b1;
                    nextState = misaligned ? DONE : BUSY;
                end
            end
            BUSY: begin
                stallRaw = 1'b1;
                if (m_ack || waitCnt == CNT_LIMIT) begin
                    nextState = DONE;
                end
            end
            DONE:    nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // Gated so the pipeline is released the instant reset is asserted.
    assign stall = stallRaw & reset;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            waitCnt   <= '0;
            loadTypeQ <= LT_WORD;
            offsetQ   <= '0;
            m_req     <= 1'b0;
            m_we      <= 1'b0;
            m_addr    <= '0;
            m_be      <= '0;
            m_wdata   <= '0;
            done      <= 1'b0;
            rdata     <= '0;
            exc_adel  <= 1'b0;
            exc_ades  <= 1'b0;
            bus_err   <= 1'b0;
        end else begin
            state    <= nextState;
            done     <= 1'b0;
            rdata    <= '0;
            exc_adel <= 1'b0;
            exc_ades <= 1'b0;
            bus_err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (opPresent) begin
                        if (misaligned) begin
                            done     <= 1'b1;
                            exc_adel <= isLoad;
                            exc_ades <= ~isLoad;
                        end else begin
                            m_req     <= 1'b1;
                            m_we      <= ~isLoad;
                            m_addr    <= {addr[31:2], 2'b00};
                            m_be      <= beNext;
                            m_wdata   <= wdataNext;
                            loadTypeQ <= load_type;
                            offsetQ   <= addr[1:0];
                            waitCnt   <= '0;
                        end
                    end
                end
                BUSY: begin
                    if (m_ack) begin
                        m_req <= 1'b0;
                        done  <= 1'b1;
                        rdata <= m_we ? '0 : extWord;
                    end else if (waitCnt == CNT_LIMIT) begin
                        m_req   <= 1'b0;
                        done    <= 1'b1;
                        bus_err <= 1'b1;
                    end else begin
                        waitCnt <= waitCnt + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Bench for dmem_access_ctrl: directed scenarios plus randomized accesses,
// each checked against a reference model of the access rules.
module tb_dmem_access_ctrl;

    localparam int TMO = 4;

    logic        clk;
    logic        reset;
    logic        mem_read, mem_write;
    logic [31:0] addr, wdata;
    logic [2:0]  load_type;
    logic [1:0]  store_type;
    logic        stall, done, exc_adel, exc_ades, bus_err;
    logic [31:0] rdata;
    logic        m_req, m_we, m_ack;
    logic [31:0] m_addr, m_wdata, m_rdata;
    logic [3:0]  m_be;

    int checks = 0;
    int failures = 0;
    int cycNum = 0;
    int lastDoneCyc = 0;
    int lastReqCyc = 0;
    int firstDone;

    logic        rRd, rWr;
    logic [31:0] rAddr, rWd, rWord;
    logic [2:0]  rLt;
    logic [1:0]  rSt;
    int          rAck;

    dmem_access_ctrl #(.TIMEOUT(TMO)) dut (
        .clk        (clk),
        .reset      (reset),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .addr       (addr),
        .wdata      (wdata),
        .load_type  (load_type),
        .store_type (store_type),
        .stall      (stall),
        .done       (done),
        .rdata      (rdata),
        .exc_adel   (exc_adel),
        .exc_ades   (exc_ades),
        .bus_err    (bus_err),
        .m_req      (m_req),
        .m_we       (m_we),
        .m_addr     (m_addr),
        .m_be       (m_be),
        .m_wdata    (m_wdata),
        .m_ack      (m_ack),
        .m_rdata    (m_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cycNum <= cycNum + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] refLoad(input logic [31:0] w, input int lt, input int off);
        logic [31:0] b;
        logic [31:0] h;
        b = (w >> (8 * off)) & 32'hFF;
        h = (w >> (16 * (off / 2))) & 32'hFFFF;
        case (lt)
            0: return w;
            1: return b;
            2: return (b >= 128) ? b + 32'hFFFFFF00 : b;
            3: return h;
            4: return (h >= 32768) ? h + 32'hFFFF0000 : h;
            default: return 32'h0;
        endcase
    endfunction

    // Presents one MEM-stage op, plays the memory side, checks the outcome.
    // Starts and ends 1 time unit after a rising edge.
    task automatic runOp(input string tag, input logic rd, input logic wr,
                         input logic [31:0] a, input logic [31:0] wd,
                         input logic [2:0] lt, input logic [1:0] st,
                         input int ackAt, input logic [31:0] memWord);
        int          off, busyExp, stallCnt, busyCnt, firstReq;
        logic        misal, isStore, expErr, gotDone;
        logic [3:0]  expBe;
        logic [31:0] expWd, expRd;
        off     = int'(a % 4);
        isStore = !rd && wr;
        if (rd) misal = (lt == 0 && off != 0) || ((lt == 3 || lt == 4) && off % 2 != 0);
        else    misal = (st == 0 && off != 0) || (st == 2 && off % 2 != 0);
        expBe = 4'hF;
        expWd = wd;
        if (isStore && st == 1) begin
            expBe = 4'(1 << off);
            expWd = (wd & 32'hFF) * 32'h01010101;
        end
        if (isStore && st == 2) begin
            expBe = (off >= 2) ? 4'hC : 4'h3;
            expWd = (wd & 32'hFFFF) * 32'h00010001;
        end
        expErr  = !misal && (ackAt < 1 || ackAt > TMO);
        busyExp = misal ? 0 : (expErr ? TMO : ackAt);
        expRd   = (rd && !misal && !expErr) ? refLoad(memWord, int'(lt), off) : 32'h0;

        mem_read = rd; mem_write = wr; addr = a; wdata = wd;
        load_type = lt; store_type = st;
        stallCnt = 0; busyCnt = 0; firstReq = -1; gotDone = 1'b0;
        for (int cyc = 0; cyc < TMO + 8 && !gotDone; cyc++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                gotDone = 1'b1;
                lastDoneCyc = cycNum;
                check({tag, ".done_stall"}, stall, 1'b0);
                check({tag, ".done_mreq"}, m_req, 1'b0);
                check({tag, ".rdata"}, rdata, expRd);
                check({tag, ".exc_adel"}, exc_adel, rd && misal);
                check({tag, ".exc_ades"}, exc_ades, !rd && misal);
                check({tag, ".bus_err"}, bus_err, expErr);
                check({tag, ".stall_cycles"}, stallCnt, misal ? 1 : busyExp + 1);
                check({tag, ".busy_cycles"}, busyCnt, busyExp);
                m_ack = 1'($urandom_range(0, 1));
            end else begin
                if (stall === 1'b1) stallCnt++;
                if (m_req === 1'b1) begin
                    busyCnt++;
                    if (firstReq < 0) begin
                        firstReq = cyc;
                        lastReqCyc = cycNum;
                    end
                    check({tag, ".m_addr"}, m_addr, a & 32'hFFFFFFFC);
                    check({tag, ".m_be"}, m_be, expBe);
                    check({tag, ".m_we"}, m_we, isStore);
                    if (isStore) check({tag, ".m_wdata"}, m_wdata, expWd);
                    m_ack   = (busyCnt == ackAt);
                    m_rdata = m_ack ? memWord : $urandom();
                end else begin
                    m_ack   = 1'($urandom_range(0, 1));
                    m_rdata = $urandom();
                end
            end
        end
        check({tag, ".done_seen"}, gotDone, 1'b1);
        if (!misal) check({tag, ".req_start"}, firstReq, 1);
        @(posedge clk);
        #1;
        mem_read = 1'b0; mem_write = 1'b0; m_ack = 1'b0;
    endtask

    initial begin
        reset = 1'b0;
        mem_read = 1'b0; mem_write = 1'b0; addr = '0; wdata = '0;
        load_type = '0; store_type = '0; m_ack = 1'b0; m_rdata = '0;
        #12;
        check("rst.m_req", m_req, 1'b0);
        check("rst.m_we", m_we, 1'b0);
        check("rst.done", done, 1'b0);
        check("rst.stall", stall, 1'b0);
        check("rst.m_addr", m_addr, 32'h0);
        check("rst.m_be", m_be, 4'h0);
        check("rst.m_wdata", m_wdata, 32'h0);
        check("rst.rdata", rdata, 32'h0);
        check("rst.exc", {exc_adel, exc_ades, bus_err}, 3'b000);
        @(posedge clk);
        #1;
        reset = 1'b1;

        runOp("lb", 1'b1, 1'b0, 32'h00000103, 32'h0, 3'd2, 2'd0, 1, 32'h80FF1234);
        runOp("sh", 1'b0, 1'b1, 32'h00000202, 32'h0000ABCD, 3'd0, 2'd2, 4, 32'h0);
        runOp("lw_misal", 1'b1, 1'b0, 32'h00000006, 32'h0, 3'd0, 2'd0, 1, 32'h12345678);
        runOp("sh_misal", 1'b0, 1'b1, 32'h00000001, 32'h1111, 3'd0, 2'd2, 1, 32'h0);
        runOp("lhu_tmo", 1'b1, 1'b0, 32'h00000012, 32'h0, 3'd3, 2'd0, 0, 32'hDEADBEEF);
        runOp("lhu_ack4", 1'b1, 1'b0, 32'h00000012, 32'h0, 3'd3, 2'd0, 4, 32'hDEADBEEF);
        runOp("rd_wins", 1'b1, 1'b1, 32'h00000020, 32'h55, 3'd4, 2'd1, 2, 32'h00008001);

        runOp("b2b_sb", 1'b0, 1'b1, 32'h00000301, 32'h0000005A, 3'd0, 2'd1, 2, 32'h0);
        firstDone = lastDoneCyc;
        runOp("b2b_lbu", 1'b1, 1'b0, 32'h00000412, 32'h0, 3'd1, 2'd0, 1, 32'hCAFE9876);
        check("b2b.req_gap", lastReqCyc - firstDone, 2);

        // Abandon a load in BUSY by asserting reset between clock edges.
        mem_read = 1'b1; mem_write = 1'b0; addr = 32'h00000040; load_type = 3'd0;
        m_ack = 1'b0;
        repeat (3) @(negedge clk);
        check("rstmid.req_before", m_req, 1'b1);
        #2;
        reset = 1'b0;
        #1;
        check("rstmid.m_req", m_req, 1'b0);
        check("rstmid.stall", stall, 1'b0);
        check("rstmid.done", done, 1'b0);
        @(posedge clk);
        #1;
        check("rstmid.m_addr", m_addr, 32'h0);
        mem_read = 1'b0;
        reset = 1'b1;
        runOp("lw_after_rst", 1'b1, 1'b0, 32'h00000044, 32'h0, 3'd0, 2'd0, 2, 32'h0BADF00D);

        for (int i = 0; i < 40; i++) begin
            rRd   = 1'($urandom_range(0, 1));
            rWr   = rRd ? 1'($urandom_range(0, 1)) : 1'b1;
            rAddr = $urandom();
            rWd   = $urandom();
            rWord = $urandom();
            rLt   = 3'($urandom_range(0, 7));
            rSt   = 2'($urandom_range(0, 2));
            rAck  = int'($urandom_range(0, TMO + 1));
            runOp("rand", rRd, rWr, rAddr, rWd, rLt, rSt, rAck, rWord);
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
